full_sync_encryptor_hs: RTL and testbench

Sequential TEA block encryptor, the transmit-side counterpart of full_sync_decryptor. Encrypts a 64-bit plaintext block under a 128-bit key, one full TEA round (both halves) per enabled clock, 32 rounds. Uses valid/ready handshakes on input and output so it can feed a link or the decryptor chain directly. Ciphertext must decrypt back to the plaintext through full_sync_decryptor / full_comb_decryptor.

---
 rtl/tea_pkg.sv | 29 ++
 rtl/tea_enc_round.sv | 25 ++
 rtl/full_sync_encryptor_hs.sv | 122 ++++++++++++
 tb/tb_full_sync_encryptor_hs.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// TEA constants, state encoding and word-level views of the block and key.
// Shared by the encryptor and the decryptors; no logic.
package tea_pkg;

   localparam int          TEA_ROUNDS  = 32;
   localparam logic [31:0] TEA_DELTA   = 32'h9E3779B9;
   localparam int          TEA_WORD_W  = 32;
   localparam int          TEA_BLOCK_W = 64;
   localparam int          TEA_KEY_W   = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } teaState_t;

   typedef struct packed {
      logic [TEA_WORD_W-1:0] v0;
      logic [TEA_WORD_W-1:0] v1;
   } teaBlock_t;

   typedef struct packed {
      logic [TEA_WORD_W-1:0] k0;
      logic [TEA_WORD_W-1:0] k1;
      logic [TEA_WORD_W-1:0] k2;
      logic [TEA_WORD_W-1:0] k3;
   } teaKey_t;

endpackage

// File: rtl/tea_enc_round.sv
// One full TEA encryption round (both halves), purely combinational.
// Zero latency, no flow control: the caller decides when to register the result.
module tea_enc_round
   import tea_pkg::*;
#(
   parameter logic [TEA_WORD_W-1:0] DELTA = TEA_DELTA
) (
   input  logic [TEA_WORD_W-1:0] v0,
   input  logic [TEA_WORD_W-1:0] v1,
   input  logic [TEA_WORD_W-1:0] sum,
   input  logic [TEA_WORD_W-1:0] k0,
   input  logic [TEA_WORD_W-1:0] k1,
   input  logic [TEA_WORD_W-1:0] k2,
   input  logic [TEA_WORD_W-1:0] k3,
   output logic [TEA_WORD_W-1:0] v0Next,
   output logic [TEA_WORD_W-1:0] v1Next,
   output logic [TEA_WORD_W-1:0] sumNext
);

   // The second half mixes the already-updated v0, so the two halves chain.
   assign sumNext = sum + DELTA;
   assign v0Next  = v0 + (((v1 << 4) + k0) ^ (v1 + sumNext) ^ ((v1 >> 5) + k1));
   assign v1Next  = v1 + (((v0Next << 4) + k2) ^ (v0Next + sumNext) ^ ((v0Next >> 5) + k3));

endmodule

// File: rtl/full_sync_encryptor_hs.sv
// Sequential TEA encryptor, one round per enabled cycle; out_valid 32 enabled cycles after accept.
// Backpressure: the ciphertext is held in DONE until out_ready; no new block is accepted until then.
module full_sync_encryptor_hs
   import tea_pkg::*;
#(
   parameter int          ROUNDS = TEA_ROUNDS,
   parameter logic [31:0] DELTA  = TEA_DELTA
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ena,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [TEA_BLOCK_W-1:0] inBlock64,
   input  logic [TEA_KEY_W-1:0]   key,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [TEA_BLOCK_W-1:0] outBlock64,
   output logic                   busy
);

   localparam int CNT_W = $clog2(ROUNDS + 1);

   teaState_t             state;
   teaState_t             stateNext;
   teaBlock_t             blk;
   teaKey_t               keyReg;
   logic [TEA_WORD_W-1:0] sum;
   logic [CNT_W-1:0]      roundCnt;
   logic [TEA_BLOCK_W-1:0] outReg;

   logic [TEA_WORD_W-1:0] v0Next;
   logic [TEA_WORD_W-1:0] v1Next;
   logic [TEA_WORD_W-1:0] sumNext;
   logic                  lastRound;
   logic                  accept;

   tea_enc_round #(.DELTA(DELTA)) uRound (
      .v0      (blk.v0),
      .v1      (blk.v1),
      .sum     (sum),
      .k0      (keyReg.k0),
      .k1      (keyReg.k1),
      .k2      (keyReg.k2),
      .k3      (keyReg.k3),
      .v0Next  (v0Next),
      .v1Next  (v1Next),
      .sumNext (sumNext)
   );

   assign lastRound = (roundCnt == CNT_W'(ROUNDS - 1));
   assign accept    = in_ready & in_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else if (ena) begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (in_valid)  stateNext = RUN;
         RUN:     if (lastRound) stateNext = DONE;
         DONE:    if (out_ready) stateNext = IDLE;
         default:                stateNext = IDLE;
      endcase
   end

   // Handshakes are masked during the reset cycle so nothing transfers while aborting.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: in_ready = ena & ~rst;
         RUN:  busy = 1'b1;
         DONE: begin
            busy      = 1'b1;
            out_valid = ena & ~rst;
         end
         default: ;
      endcase
   end

   // outReg is loaded only on the final round, so intermediate values never reach the port.
   always_ff @(posedge clk) begin
      if (rst) begin
         blk      <= '0;
         keyReg   <= '0;
         sum      <= '0;
         roundCnt <= '0;
         outReg   <= '0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (accept) begin
                  blk      <= inBlock64;
                  keyReg   <= key;
                  sum      <= '0;
                  roundCnt <= '0;
               end
            end
            RUN: begin
               blk.v0   <= v0Next;
               blk.v1   <= v1Next;
               sum      <= sumNext;
               roundCnt <= roundCnt + CNT_W'(1);
               if (lastRound) begin
                  outReg <= {v0Next, v1Next};
               end
            end
            default: ;
         endcase
      end
   end

   assign outBlock64 = outReg;

endmodule

// File: tb/tb_full_sync_encryptor_hs.sv
// Randomized scenario bench for full_sync_encryptor_hs against a word-level TEA model.
module tb_full_sync_encryptor_hs;

   localparam logic [31:0] MDELTA = 32'h9E3779B9;

   logic         clk;
   logic         rst;
   logic         ena;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  inBlock64;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [63:0]  outBlock64;
   logic         busy;

   int total = 0;
   int bad   = 0;

   full_sync_encryptor_hs dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .inBlock64  (inBlock64),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .outBlock64 (outBlock64),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [63:0] modelEnc(input logic [63:0] pt, input logic [127:0] k);
      bit [31:0] a, b, s;
      a = pt[63:32];
      b = pt[31:0];
      s = 32'd0;
      for (int i = 0; i < 32; i++) begin
         s = s + MDELTA;
         a = a + (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
         b = b + (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
      end
      return {a, b};
   endfunction

   function automatic logic [63:0] modelDec(input logic [63:0] ct, input logic [127:0] k);
      bit [31:0] a, b, s;
      a = ct[63:32];
      b = ct[31:0];
      s = MDELTA * 32;
      for (int i = 0; i < 32; i++) begin
         b = b - (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
         a = a - (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
         s = s - MDELTA;
      end
      return {a, b};
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] pt, input logic [127:0] k);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL send_ready: in_ready=%b want 1", in_ready);
      end
      in_valid  = 1'b1;
      inBlock64 = pt;
      key       = k;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic waitOut(output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (out_valid !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL wait_out_timeout: out_valid=%b after %0d cycles", out_valid, n);
      end
   endtask

   task automatic take();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ena = 1'b1;
      tick();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
      end
      tick();
      total++;
      if (busy !== 1'b0 || outBlock64 !== 64'h0) begin
         bad++;
         $display("FAIL reset_regs: busy=%b out=%h want 0 0", busy, outBlock64);
      end
      rst = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release: in_ready=%b want 1", in_ready);
      end
   endtask

   task automatic test_zero_vector();
      int n;
      send(64'h0, 128'h0);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL zero_busy: busy=%b want 1", busy);
      end
      waitOut(n);
      total++;
      if (n != 32) begin
         bad++;
         $display("FAIL zero_latency: got %0d want 32", n);
      end
      total++;
      if (outBlock64 !== 64'h41EA3A0A94BAA940) begin
         bad++;
         $display("FAIL zero_ct: got %h want 41ea3a0a94baa940", outBlock64);
      end
      take();
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL zero_after: out_valid=%b busy=%b want 0 0", out_valid, busy);
      end
   endtask

   task automatic test_random();
      int n;
      logic [63:0]  pt;
      logic [127:0] k;
      for (int i = 0; i < 100; i++) begin
         pt = rand64();
         k  = rand128();
         send(pt, k);
         waitOut(n);
         total++;
         if (n != 32) begin
            bad++;
            $display("FAIL rand_latency[%0d]: got %0d want 32", i, n);
         end
         total++;
         if (outBlock64 !== modelEnc(pt, k)) begin
            bad++;
            $display("FAIL rand_ct[%0d]: got %h want %h", i, outBlock64, modelEnc(pt, k));
         end
         total++;
         if (modelDec(outBlock64, k) !== pt) begin
            bad++;
            $display("FAIL rand_roundtrip[%0d]: got %h want %h", i, modelDec(outBlock64, k), pt);
         end
         repeat ($urandom_range(0, 3)) tick();
         take();
      end
   endtask

   task automatic test_backpressure();
      int n;
      logic [63:0]  pt;
      logic [127:0] k;
      logic [63:0]  ct;
      pt = rand64();
      k  = rand128();
      send(pt, k);
      waitOut(n);
      ct = modelEnc(pt, k);
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if (out_valid !== 1'b1 || outBlock64 !== ct || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold[%0d]: out_valid=%b out=%h in_ready=%b want 1 %h 0",
                     i, out_valid, outBlock64, in_ready, ct);
         end
      end
      take();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || outBlock64 !== ct) begin
         bad++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b out=%h want 1 0 %h",
                  in_ready, out_valid, outBlock64, ct);
      end
   endtask

   task automatic test_ena_gating();
      int n;
      logic [63:0]  pt;
      logic [127:0] k;
      pt = rand64();
      k  = rand128();
      send(pt, k);
      repeat (10) tick();
      ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL ena_low[%0d]: in_ready=%b out_valid=%b want 0 0", i, in_ready, out_valid);
         end
         tick();
      end
      ena = 1'b1;
      waitOut(n);
      total++;
      if (10 + 5 + n != 37) begin
         bad++;
         $display("FAIL ena_latency: got %0d want 37", 10 + 5 + n);
      end
      total++;
      if (outBlock64 !== modelEnc(pt, k)) begin
         bad++;
         $display("FAIL ena_ct: got %h want %h", outBlock64, modelEnc(pt, k));
      end
      ena = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL ena_done_hold: out_valid=%b busy=%b want 0 1", out_valid, busy);
      end
      ena = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL ena_done_resume: out_valid=%b want 1", out_valid);
      end
      take();
   endtask

   task automatic test_reset_mid();
      int n;
      logic [63:0]  pt;
      logic [127:0] k;
      send(rand64(), rand128());
      repeat (16) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || outBlock64 !== 64'h0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid: busy=%b out_valid=%b out=%h in_ready=%b want 0 0 0 1",
                  busy, out_valid, outBlock64, in_ready);
      end
      pt = rand64();
      k  = rand128();
      send(pt, k);
      waitOut(n);
      total++;
      if (n != 32 || outBlock64 !== modelEnc(pt, k)) begin
         bad++;
         $display("FAIL rst_mid_next: n=%0d out=%h want 32 %h", n, outBlock64, modelEnc(pt, k));
      end
      take();
   endtask

   task automatic test_input_stability();
      int n;
      logic [63:0]  pt;
      logic [63:0]  pt2;
      logic [127:0] k;
      logic [127:0] k2;
      pt = rand64();
      k  = rand128();
      send(pt, k);
      in_valid = 1'b1;
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin
         inBlock64 = rand64();
         key       = rand128();
         tick();
         n++;
      end
      total++;
      if (n != 32 || outBlock64 !== modelEnc(pt, k)) begin
         bad++;
         $display("FAIL stab_ct: n=%0d out=%h want 32 %h", n, outBlock64, modelEnc(pt, k));
      end
      repeat (2) tick();
      total++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL stab_hold: in_ready=%b busy=%b want 0 1", in_ready, busy);
      end
      pt2 = rand64();
      k2  = rand128();
      inBlock64 = pt2;
      key       = k2;
      take();
      total++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL stab_no_accept: busy=%b in_ready=%b want 0 1", busy, in_ready);
      end
      tick();
      in_valid = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL stab_second_accept: busy=%b want 1", busy);
      end
      waitOut(n);
      total++;
      if (n != 32 || outBlock64 !== modelEnc(pt2, k2)) begin
         bad++;
         $display("FAIL stab_second_ct: n=%0d out=%h want 32 %h", n, outBlock64, modelEnc(pt2, k2));
      end
      take();
   endtask

   initial begin
      rst       = 1'b1;
      ena       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      inBlock64 = '0;
      key       = '0;
      test_reset();
      test_zero_vector();
      test_random();
      test_backpressure();
      test_ena_gating();
      test_reset_mid();
      test_input_stability();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
